mem_req_issuer: RTL and testbench



---
 rtl/mem_req_pkg.sv | 24 ++
 rtl/mem_req_fifo.sv | 56 +++++
 rtl/mem_req_issuer.sv | 153 +++++++++++++++
 tb/tb_mem_req_issuer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared types and defaults for the memory request issuer.
package mem_req_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NUDGE,
        PRESENT,
        ACK,
        DONE,
        RESP
    } state_e;

    localparam int REQ_AW = 32;
    localparam int REQ_DW = 32;

    typedef struct packed {
        logic              mode;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] data;
    } mem_req_t;

    localparam logic [REQ_AW-1:0] NUDGE_XOR_DFLT = 32'h4;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO; full/empty derived from an occupancy count one bit wider than the pointers.
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  slot_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) slot_q[wr_ptr_q] <= wdata;
    end

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = slot_q[rd_ptr_q];

endmodule

// File: rtl/mem_req_issuer.sv
// Issues queued CPU requests to a change-detecting front-end port, forcing a visible
// change (nudge read) when a request repeats the last presented tuple.
module mem_req_issuer
    import mem_req_pkg::*;
#(
    parameter int            DEPTH     = 4,
    parameter int            AW        = REQ_AW,
    parameter int            DW        = REQ_DW,
    parameter int            TIMEOUT   = 64,
    parameter logic [AW-1:0] NUDGE_XOR = AW'(NUDGE_XOR_DFLT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_mode,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_mode,
    input  logic          mem_response,
    input  logic [DW-1:0] mem_out,
    output logic          busy
);

    localparam int RW = 1 + AW + DW;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic          mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    state_e        state_q, state_d;
    req_t          cur_q, cur_d;
    req_t          mem_q, mem_d;
    logic          nudge_q, nudge_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          err_q, err_d;

    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [RW-1:0] fifo_head;
    req_t          head;

    assign req_ready = !fifo_full && !rst;
    assign fifo_push = req_valid && req_ready;
    assign head      = fifo_head;

    mem_req_fifo #(
        .DEPTH(DEPTH),
        .W    (RW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .wdata({req_mode, req_addr, req_data}),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (fifo_head)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        mem_d      = mem_q;
        nudge_d    = nudge_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = head;
                    state_d  = (head == mem_q) ? NUDGE : PRESENT;
                end
            end
            NUDGE: begin
                // Read-mode neighbour address; data kept so only addr/mode change.
                mem_d.addr = mem_q.addr ^ NUDGE_XOR;
                mem_d.mode = 1'b0;
                nudge_d    = 1'b1;
                cnt_d      = '0;
                state_d    = ACK;
            end
            PRESENT: begin
                mem_d   = cur_q;
                nudge_d = 1'b0;
                cnt_d   = '0;
                state_d = ACK;
            end
            ACK, DONE: begin
                if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    rsp_data_d = '0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (state_q == ACK) begin
                        if (mem_response) state_d = DONE;
                    end else if (!mem_response) begin
                        if (nudge_q) begin
                            state_d = PRESENT;
                        end else begin
                            err_d      = 1'b0;
                            rsp_data_d = cur_q.mode ? '0 : mem_out;
                            state_d    = RESP;
                        end
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            mem_q      <= '0;
            nudge_q    <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            mem_q      <= mem_d;
            nudge_q    <= nudge_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign rsp_valid   = (state_q == RESP);
    assign rsp_err     = rsp_valid && err_q;
    assign rsp_data    = rsp_data_q;
    assign mem_address = mem_q.addr;
    assign mem_data    = mem_q.data;
    assign mem_mode    = mem_q.mode;
    assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mem_req_issuer.sv
// Randomized bench for mem_req_issuer with a behavioural front-end and in-order scoreboard.
module tb_mem_req_issuer;

    localparam int DEPTH   = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_mode = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready, rsp_valid, rsp_err, mem_mode, busy;
    logic [DW-1:0] rsp_data, mem_data;
    logic [AW-1:0] mem_address;
    logic          mem_response = 1'b0;
    logic [DW-1:0] mem_out = '0;

    always #5 clk = ~clk;

    mem_req_issuer #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .NUDGE_XOR(32'h4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_data(mem_data), .mem_mode(mem_mode),
        .mem_response(mem_response), .mem_out(mem_out), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural front-end: reacts to any change of the mem_* tuple.
    logic [DW-1:0] fe_mem [logic [AW-1:0]];
    logic [64:0]   fe_last = '0;
    int            fe_phase = 0, fe_cnt = 0, fe_hold = 1, fe_hold_fix = 1;
    bit            fe_stall = 0, fe_dead = 0, fe_rand = 0;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(negedge clk) begin : fe_model
        logic [64:0] tup;
        tup = {mem_mode, mem_address, mem_data};
        if (rst) begin
            fe_last = '0; fe_phase = 0; mem_response = 1'b0;
        end else begin
            if (tup != fe_last) begin
                fe_last  = tup;
                fe_phase = fe_dead ? 0 : 1;
            end
            if (fe_phase == 2) begin
                if (fe_cnt >= fe_hold) begin
                    mem_response = 1'b0;
                    fe_phase = 0;
                    if (fe_last[64]) fe_mem[fe_last[63:32]] = fe_last[31:0];
                    else mem_out = fe_mem.exists(fe_last[63:32]) ? fe_mem[fe_last[63:32]]
                                                                : dflt(fe_last[63:32]);
                end else fe_cnt++;
            end else if (fe_phase == 1 && !fe_stall && !fe_dead) begin
                mem_response = 1'b1;
                fe_phase = 2;
                fe_cnt = 1;
                fe_hold = fe_rand ? int'($urandom_range(1, 3)) : fe_hold_fix;
            end
        end
    end

    // Reference model: ordered expected responses and expected presentations.
    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            lat;
    } exp_t;

    exp_t          exp_q[$];
    logic [64:0]   pres_q[$];
    logic [64:0]   pres_last = '0;
    logic [64:0]   mon_last = '0;
    logic [DW-1:0] shadow [logic [AW-1:0]];
    int            cyc = 0;
    int            n_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        logic [64:0] tup;
        exp_t e;
        tup = {mem_mode, mem_address, mem_data};
        if (rst) begin
            mon_last = '0;
        end else begin
            if (tup != mon_last) begin
                mon_last = tup;
                chk("pres_expected", pres_q.size() > 0, 1);
                if (pres_q.size() > 0) chk("pres_tuple", tup, pres_q.pop_front());
            end
            if (rsp_valid) begin
                n_rsp++;
                chk("rsp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    if (e.lat >= 0) chk("rsp_latency", cyc + 1, e.lat);
                end
            end
        end
    end

    task automatic push(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int lat, input logic err);
        int   n = 0;
        bit   ok = 0;
        exp_t e;
        logic [64:0] t;
        while (!ok && n < 200) begin
            @(negedge clk);
            req_valid = 1'b1; req_mode = m; req_addr = a; req_data = d;
            ok = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        chk("push_accept", ok, 1);
        if (ok) begin
            t = {m, a, d};
            if (t == pres_last) pres_q.push_back({1'b0, a ^ 32'h4, d});
            pres_q.push_back(t);
            pres_last = t;
            e.err  = err;
            e.data = (m || err) ? '0 : (shadow.exists(a) ? shadow[a] : dflt(a));
            e.lat  = (lat < 0) ? -1 : cyc + lat;
            if (m && !err) shadow[a] = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (exp_q.size() == 0) && !busy, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int base, n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_mode", mem_mode, 0);
        chk("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        // All-zero read after reset: nudged, three extra cycles.
        push(1'b0, 32'h0, 32'h0, 8, 1'b0);
        drain();

        // Write then read back, minimum latency on the write.
        push(1'b1, 32'h10, 32'hAB, 5, 1'b0);
        push(1'b0, 32'h10, 32'h0, -1, 1'b0);
        drain();

        // Repeated read is nudged through 0x24.
        push(1'b0, 32'h20, 32'h0, -1, 1'b0);
        push(1'b0, 32'h20, 32'h0, -1, 1'b0);
        drain();

        // Fill while the front-end stalls.
        fe_stall = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [31:0] iv;
            iv = i;
            push(iv[0], 32'h100 + 4 * iv, 32'h1000 + iv, -1, 1'b0);
        end
        @(negedge clk);
        chk("full_ready", req_ready, 0);
        chk("full_busy", busy, 1);
        repeat (3) @(negedge clk);
        fe_stall = 0;
        drain();

        // Front-end never answers the first request.
        fe_dead = 1;
        base = n_rsp;
        push(1'b0, 32'h300, 32'h0, TIMEOUT + 3, 1'b1);
        push(1'b0, 32'h304, 32'h0, -1, 1'b0);
        n = 0;
        while (n_rsp == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_seen", n_rsp > base, 1);
        fe_dead = 0;
        drain();

        // Random traffic over a small address/data pool to provoke repeats.
        fe_rand = 1;
        for (int i = 0; i < 60; i++) begin
            logic m;
            logic [31:0] a, d;
            m = 1'($urandom_range(0, 1));
            a = 32'h40 + 4 * $urandom_range(0, 3);
            d = m ? 32'($urandom_range(0, 3)) : 32'h0;
            push(m, a, d, -1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        fe_rand = 0;

        // Reset while the head request waits in DONE with two more queued.
        fe_hold_fix = 8;
        push(1'b0, 32'h500, 32'h0, -1, 1'b0);
        push(1'b0, 32'h504, 32'h0, -1, 1'b0);
        push(1'b0, 32'h508, 32'h0, -1, 1'b0);
        n = 0;
        while (!mem_response && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_ack_seen", mem_response, 1);
        repeat (2) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        exp_q.delete();
        pres_q.delete();
        @(negedge clk);
        chk("mid_rst_mem_address", mem_address, 0);
        chk("mid_rst_mem_data", mem_data, 0);
        chk("mid_rst_mem_mode", mem_mode, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        pres_last = '0;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 1);
        repeat (30) @(negedge clk);
        chk("mid_rst_quiet_busy", busy, 0);

        chk("rsp_left", exp_q.size(), 0);
        chk("pres_left", pres_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
